// File: rtl/fpu_divsqrt_iter_if.sv
// Request/response bundle for the iterative divide/sqrt significand core.
// master drives operands and the result-ready; slave is the core.
interface fpu_divsqrt_iter_if #(
  parameter int MAN_WIDTH = 23,
  parameter int TAG_WIDTH = 1
);
  localparam int QUO_WIDTH = MAN_WIDTH + 3;

  logic [MAN_WIDTH:0]   i_op_a;
  logic [MAN_WIDTH:0]   i_op_b;
  logic                 i_is_sqrt;
  logic                 i_exp_odd;
  logic [TAG_WIDTH-1:0] i_tag;
  logic                 i_flush;
  logic                 i_in_valid;
  logic                 o_in_ready;
  logic [QUO_WIDTH-1:0] o_quo;
  logic                 o_sticky;
  logic [TAG_WIDTH-1:0] o_tag;
  logic                 o_out_valid;
  logic                 i_out_ready;

  modport master (
    output i_op_a, i_op_b, i_is_sqrt, i_exp_odd, i_tag, i_flush, i_in_valid, i_out_ready,
    input  o_in_ready, o_quo, o_sticky, o_tag, o_out_valid
  );

  modport slave (
    input  i_op_a, i_op_b, i_is_sqrt, i_exp_odd, i_tag, i_flush, i_in_valid, i_out_ready,
    output o_in_ready, o_quo, o_sticky, o_tag, o_out_valid
  );
endinterface

// File: rtl/fpu_divsqrt_iter.sv
// Radix-2 restoring significand divide / square root, one result bit per cycle.
// Quotient/root is truncated; sticky flags a nonzero final remainder.
module fpu_divsqrt_iter #(
  parameter int MAN_WIDTH = 23,
  parameter int TAG_WIDTH = 1
) (
  input logic               i_clk,
  input logic               i_rst_n,
  fpu_divsqrt_iter_if.slave bus
);
  localparam int QUO_WIDTH = MAN_WIDTH + 3;
  localparam int REM_WIDTH = QUO_WIDTH + 2;
  localparam int RAD_WIDTH = 2 * QUO_WIDTH;
  localparam int CNT_WIDTH = $clog2(QUO_WIDTH + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [REM_WIDTH-1:0] rem_q, rem_d;
  logic [RAD_WIDTH-1:0] rad_q, rad_d;
  logic [MAN_WIDTH:0]   div_q, div_d;
  logic [QUO_WIDTH-1:0] quo_q, quo_d;
  logic                 sqrt_q, sqrt_d;
  logic                 sticky_q, sticky_d;
  logic [TAG_WIDTH-1:0] tag_q, tag_d;

  logic [REM_WIDTH-1:0] cmp, trial;
  logic [REM_WIDTH:0]   diff;
  logic                 ge;

  // Sqrt brings down two radicand bits per step and trials 4*root+1;
  // divide trials the divisor and shifts the remainder after the step.
  always_comb begin
    if (sqrt_q) begin
      cmp   = {rem_q[REM_WIDTH-3:0], rad_q[RAD_WIDTH-1 -: 2]};
      trial = {quo_q, 2'b01};
    end else begin
      cmp   = rem_q;
      trial = REM_WIDTH'(div_q);
    end
    diff = {1'b0, cmp} - {1'b0, trial};
    ge   = ~diff[REM_WIDTH];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    rad_d    = rad_q;
    div_d    = div_q;
    quo_d    = quo_q;
    sqrt_d   = sqrt_q;
    sticky_d = sticky_q;
    tag_d    = tag_q;
    if (bus.i_flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (bus.i_in_valid) begin
          state_d  = BUSY;
          cnt_d    = CNT_WIDTH'(QUO_WIDTH);
          sqrt_d   = bus.i_is_sqrt;
          tag_d    = bus.i_tag;
          div_d    = bus.i_op_b;
          quo_d    = '0;
          sticky_d = 1'b0;
          // Odd exponent doubles the radicand; low bits pad the root to QUO_WIDTH bits.
          rad_d    = {(bus.i_exp_odd ? {bus.i_op_a, 1'b0} : {1'b0, bus.i_op_a}),
                      {(MAN_WIDTH+4){1'b0}}};
          rem_d    = bus.i_is_sqrt ? '0 : REM_WIDTH'(bus.i_op_a);
        end
        BUSY: if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_WIDTH'(1);
          quo_d = {quo_q[QUO_WIDTH-2:0], ge};
          rad_d = rad_q << 2;
          if (sqrt_q) rem_d = ge ? diff[REM_WIDTH-1:0] : cmp;
          else        rem_d = (ge ? diff[REM_WIDTH-1:0] : cmp) << 1;
        end else begin
          state_d  = DONE;
          sticky_d = |rem_q;
        end
        DONE: if (bus.i_out_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      rad_q    <= '0;
      div_q    <= '0;
      quo_q    <= '0;
      sqrt_q   <= 1'b0;
      sticky_q <= 1'b0;
      tag_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      rad_q    <= rad_d;
      div_q    <= div_d;
      quo_q    <= quo_d;
      sqrt_q   <= sqrt_d;
      sticky_q <= sticky_d;
      tag_q    <= tag_d;
    end
  end

  assign bus.o_in_ready  = (state_q == IDLE);
  assign bus.o_out_valid = (state_q == DONE);
  assign bus.o_quo       = quo_q;
  assign bus.o_sticky    = sticky_q;
  assign bus.o_tag       = tag_q;
endmodule

// File: doc/fpu_divsqrt_iter.md
# fpu_divsqrt_iter

Iterative radix-2 significand divide/square-root core for the FPU's FDIV/FSQRT path. It takes normalised significands with the hidden bit set and produces a truncated quotient or root plus a sticky bit. It generates one result bit per cycle under a valid/ready handshake. Exponent handling, special-case detection (NaN/inf/zero), normalisation and rounding stay in the enclosing FDIVSQRT wrapper; this core covers only the multi-cycle significand datapath.

## Interface
Parameters:
- MAN_WIDTH, default 23: stored mantissa bits. Use 23 for FP32 and 52 for FP64.
- TAG_WIDTH, default 1: width of the opaque sideband carried from input to output.
- QUO_WIDTH (localparam) = MAN_WIDTH+3: number of result bits. Weights run from 2^0 down to 2^-(MAN_WIDTH+2).

Ports (clock and reset first):
- i_clk  in  1  clock, rising edge. This block uses one clock only.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_op_a  in  MAN_WIDTH+1  dividend or radicand significand, 1.f format, MSB = hidden bit.
- i_op_b  in  MAN_WIDTH+1  divisor significand, 1.f format. Ignored for sqrt.
- i_is_sqrt  in  1  1 selects square root, 0 selects divide.
- i_exp_odd  in  1  sqrt only. 1 means the unbiased exponent is odd, so the radicand is doubled.
- i_tag  in  TAG_WIDTH  sideband, returned unchanged with the result.
- i_flush  in  1  synchronous abort.
- i_in_valid  in  1  request valid.
- o_in_ready  out  1  core can accept a request.
- o_quo  out  QUO_WIDTH  truncated quotient or root.
- o_sticky  out  1  1 when the discarded remainder is nonzero.
- o_tag  out  TAG_WIDTH  tag of the completed operation.
- o_out_valid  out  1  result valid.
- i_out_ready  in  1  consumer accepts the result.

## Operation
- States: IDLE, BUSY, DONE.
  - o_in_ready = (state == IDLE).
  - o_out_valid = (state == DONE).
- IDLE → BUSY on i_in_valid & o_in_ready & !i_flush. On that edge the core captures the operands, i_is_sqrt, i_exp_odd and i_tag, and loads the iteration counter with QUO_WIDTH.
- BUSY: each cycle produces one result bit, MSB first, and decrements the counter. After the QUO_WIDTH-th iteration, the next state is DONE.
- DONE → IDLE on i_out_ready. o_quo, o_sticky and o_tag stay stable while in DONE.
- A new request is not accepted in the same cycle as the result is consumed; one idle cycle always separates operations.
- Divide result, with A = i_op_a and B = i_op_b as integers:
  - o_quo = floor(A·2^(QUO_WIDTH-1) / B).
  - o_sticky = (A·2^(QUO_WIDTH-1) mod B) != 0.
  - The quotient lies in (0.5, 2). o_quo MSB = 0 when A < B; the wrapper normalises.
- Square-root result:
  - R = A if i_exp_odd = 0, otherwise R = 2A.
  - S = R·2^(2·QUO_WIDTH-2-MAN_WIDTH).
  - o_quo = floor(sqrt(S)). o_sticky = (o_quo² != S).
  - The root lies in [1, 2), so o_quo MSB is always 1.
- The internal partial remainder is wide enough for a restoring step without overflow: MAN_WIDTH+3 bits for divide and QUO_WIDTH+2 bits for sqrt.
- i_op_a and i_op_b must have the MSB set. If not, o_quo and o_sticky are don't-care, but the handshake and latency are unchanged.
- i_flush in any state returns the core to IDLE on the next edge. In-flight or pending results are dropped, o_out_valid drops and nothing is accepted that cycle. i_flush takes priority over both accept and i_out_ready.

## Timing
- Reset values:
  - state IDLE, so o_in_ready = 1.
  - o_out_valid = 0.
  - o_quo = 0, o_sticky = 0, o_tag = 0.
  - counter = 0.
- Latency: a request accepted at edge t0 gives o_out_valid = 1 from edge t0+QUO_WIDTH+1. That is 27 cycles for FP32 and 56 for FP64.
- Throughput: one operation per QUO_WIDTH+2 cycles when i_out_ready is held at 1.
- Backpressure: DONE holds indefinitely while i_out_ready = 0.
- An asynchronous reset mid-operation forces all reset values immediately, regardless of the clock.
- o_quo, o_sticky and o_tag are registered. There is no combinational path from any input to any output.

## Test plan
Concrete values use MAN_WIDTH = 23, QUO_WIDTH = 26.
- Divide 1.0/1.0: A = 0x800000, B = 0x800000 → o_quo = 0x2000000, o_sticky = 0; o_out_valid rises 27 edges after accept.
- Divide 1.0/1.5: A = 0x800000, B = 0xC00000 → o_quo = 0x1555555, o_sticky = 1.
- Sqrt of 2: A = 0x800000, i_exp_odd = 1 → o_quo = 0x2D413CC, o_sticky = 1.
- Sqrt of 2.25: A = 0x900000, i_exp_odd = 1 → o_quo = 0x3000000, o_sticky = 0.
- Sqrt of 1.0: A = 0x800000, i_exp_odd = 0 → o_quo = 0x2000000, o_sticky = 0.
- Backpressure and tag: hold i_out_ready = 0 for 10 cycles in DONE → o_quo and o_tag stay stable and o_in_ready stays 0; after release, o_in_ready = 1 one cycle later.
- Flush: assert i_flush at BUSY iteration 5 → IDLE on the next edge, o_out_valid never asserts. A following request (divide 1.0/1.5) returns 0x1555555 with the full latency.
- Reset: assert i_rst_n low mid-BUSY → all outputs take their reset values immediately. Then run random divide and sqrt requests against the floor/sticky reference model.
